// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Holds the hex glyph table (active-high {g,f,e,d,c,b,a}), the pin polarity helper
// and the divider counter width helper used by the top level.
package ssd_pkg;

    typedef logic [6:0] glyph_t;

    // Segment bit order {g,f,e,d,c,b,a}; a set bit means the segment is lit.
    localparam glyph_t GLYPH_TABLE [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    // Width of a counter running 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    // Converts an active-high "on" bit into the pin level for the board polarity.
    function automatic logic apply_pol(input logic v, input logic active_low);
        return v ^ active_low;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
// Latency: zero cycles (pure lookup). No backpressure.
// Ports: nibble (4-bit hex digit in), glyph (7-bit segment pattern out).
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned update buffering.
// Latency: pins are registered one cycle behind the scan index/shadow state; a load
// reaches the pins at the next frame boundary. No backpressure: load is always accepted.
// Ports: clk, reset (sync, active-high); value/blank_mask/dp_mask captured on load;
// an/seg/dp drive the board pins; frame_start pulses once per completed scan.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_BLANK    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Stage holds the most recent load; shadow is what is actually displayed.
    logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic                    pending_q, pending_d;

    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    // Registered pin stage
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q, frame_start_d;

    logic       boundary;
    logic [3:0] cur_nib;
    logic [6:0] cur_glyph;
    logic       lz_zero;
    logic       dark;

    ssd_hex_decoder u_dec (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    // ------------------------------------------------------------------
    // Divider, digit index and update buffering
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d          = cnt_q + CNT_W'(1);
        idx_d          = idx_q;
        boundary       = 1'b0;
        stage_val_d    = stage_val_q;
        stage_blank_d  = stage_blank_q;
        stage_dp_d     = stage_dp_q;
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        shadow_dp_d    = shadow_dp_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d    = '0;
                boundary = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Commit uses the stage contents from before this edge, so a load that
        // lands in the boundary cycle waits for the following frame.
        if (boundary && pending_q) begin
            shadow_val_d   = stage_val_q;
            shadow_blank_d = stage_blank_q;
            shadow_dp_d    = stage_dp_q;
        end

        if (load) begin
            stage_val_d   = value;
            stage_blank_d = blank_mask;
            stage_dp_d    = dp_mask;
        end

        pending_d     = load | (pending_q & ~boundary);
        frame_start_d = boundary;
    end

    // ------------------------------------------------------------------
    // Digit select, blanking and pin polarity
    // ------------------------------------------------------------------
    always_comb begin
        cur_nib = shadow_val_q[{idx_q, 2'b00} +: 4];

        // True when every nibble from the current digit upward is zero.
        lz_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && shadow_val_q[4*i +: 4] != 4'h0) begin
                lz_zero = 1'b0;
            end
        end

        dark = shadow_blank_q[idx_q]
             | ((LZ_BLANK != 0) && (idx_q != '0) && lz_zero);

        an_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = apply_pol((i == int'(idx_q)) && !dark, POL);
        end

        seg_d = '0;
        for (int s = 0; s < 7; s++) begin
            seg_d[s] = apply_pol(cur_glyph[s] & !dark, POL);
        end

        dp_d = apply_pol(shadow_dp_q[idx_q] & !dark, POL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            stage_val_q    <= '0;
            stage_blank_q  <= '0;
            stage_dp_q     <= '0;
            pending_q      <= 1'b0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            shadow_dp_q    <= '0;
            an_q           <= {NUM_DIGITS{POL}};
            seg_q          <= {7{POL}};
            dp_q           <= POL;
            frame_start_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            stage_val_q    <= stage_val_d;
            stage_blank_q  <= stage_blank_d;
            stage_dp_q     <= stage_dp_d;
            pending_q      <= pending_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: two instances (leading-zero blanking off/on)
// share clock, reset and load; expected frames are queued by the stimulus and
// checked digit-by-digit by a monitor triggered on frame_start.
module tb_ssd_scan_driver;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G5  = 7'b0010010;
    localparam logic [6:0] G7  = 7'b1111000;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] GB  = 7'b0000011;
    localparam logic [6:0] GC  = 7'b1000110;
    localparam logic [6:0] GD  = 7'b0100001;
    localparam logic [6:0] GE  = 7'b0000110;
    localparam logic [6:0] GF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    typedef struct packed {
        logic [15:0] an;
        logic [27:0] seg;
        logic [3:0]  dp;
    } view_t;

    typedef struct packed {
        view_t m;
        view_t z;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic [15:0] lz_value = '0;
    logic [3:0]  lz_blank = '0;
    logic [3:0]  lz_dp = '0;

    logic [3:0]  an, lz_an;
    logic [6:0]  seg, lz_seg;
    logic        dp, lz_dp_o;
    logic        frame_start, lz_frame_start;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int frames_done = 0;
    frame_t sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_cyc <= cyc;
    end

    ssd_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(0)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask),
        .dp_mask(dp_mask), .load(load), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start)
    );

    ssd_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut_lz (
        .clk(clk), .reset(reset), .value(lz_value), .blank_mask(lz_blank),
        .dp_mask(lz_dp), .load(load), .an(lz_an), .seg(lz_seg), .dp(lz_dp_o),
        .frame_start(lz_frame_start)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Builds the expected pin view of one frame from hand-picked glyphs.
    function automatic view_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0,
                                 input logic [3:0] dark, input logic [3:0] dpl);
        view_t      v;
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            v.an[k*4 +: 4]  = dark[k] ? 4'b1111 : 4'(~(4'b0001 << k));
            v.seg[k*7 +: 7] = dark[k] ? OFF : s[k];
            v.dp[k]         = dark[k] ? 1'b1 : ~dpl[k];
        end
        return v;
    endfunction

    task automatic chk_pins(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
        chk({tag, "_m_an"},  an,          an_e);
        chk({tag, "_m_seg"}, seg,         seg_e);
        chk({tag, "_m_dp"},  dp,          dp_e);
        chk({tag, "_m_fs"},  frame_start, 1'b0);
        chk({tag, "_z_an"},  lz_an,       an_e);
        chk({tag, "_z_seg"}, lz_seg,      seg_e);
        chk({tag, "_z_dp"},  lz_dp_o,     dp_e);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        if (frame_start !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_frame: no frame_start within %0d cycles", n);
        end
    endtask

    // Monitor: on each frame_start pop one expected frame and check every digit slot.
    initial begin
        frame_t exp;
        int     fi = 0;
        int     last_fs = -1;
        bit     have;
        forever begin
            do @(negedge clk); while (frame_start !== 1'b1);
            chk($sformatf("f%0d_lz_fs_align", fi), lz_frame_start, 1'b1);
            if (last_fs >= 0 && rst_cyc < last_fs)
                chk($sformatf("f%0d_period", fi), cyc - last_fs, 16);
            last_fs = cyc;
            have = (sb_q.size() != 0);
            if (have) begin
                exp = sb_q.pop_front();
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL f%0d_sb_empty: frame seen with no expectation queued", fi);
            end
            repeat (2) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) repeat (4) @(negedge clk);
                if (have) begin
                    chk($sformatf("f%0d_d%0d_m_an", fi, k),  an,      exp.m.an[k*4 +: 4]);
                    chk($sformatf("f%0d_d%0d_m_seg", fi, k), seg,     exp.m.seg[k*7 +: 7]);
                    chk($sformatf("f%0d_d%0d_m_dp", fi, k),  dp,      exp.m.dp[k]);
                    chk($sformatf("f%0d_d%0d_z_an", fi, k),  lz_an,   exp.z.an[k*4 +: 4]);
                    chk($sformatf("f%0d_d%0d_z_seg", fi, k), lz_seg,  exp.z.seg[k*7 +: 7]);
                    chk($sformatf("f%0d_d%0d_z_dp", fi, k),  lz_dp_o, exp.z.dp[k]);
                end
            end
            fi++;
            frames_done++;
        end
    end

    // Stimulus
    initial begin
        frame_t f;
        int     n;

        // Reset state
        repeat (3) @(negedge clk);
        chk_pins("rst", 4'b1111, OFF, 1'b1);

        // F1: power-on zeros (LZ instance shows digit 0 only)
        f.m = mk(G0, G0, G0, G0, 4'b0000, 4'b0000);
        f.z = mk(OFF, OFF, OFF, G0, 4'b1110, 4'b0000);
        sb_q.push_back(f);

        reset = 1'b0;
        @(negedge clk);
        chk_pins("first", 4'b1110, G0, 1'b1);

        // Mid-frame loads during F1; the second one wins and shows from F2.
        wait_frame();
        f.m = mk(G1, G2, GA, GF, 4'b0000, 4'b0000);
        f.z = mk(OFF, OFF, G3, G0, 4'b1100, 4'b0000);
        sb_q.push_back(f);
        repeat (6) @(negedge clk);
        value = 16'hFFFF; lz_value = 16'h0030; load = 1'b1;
        @(negedge clk);
        value = 16'h12AF;
        @(negedge clk);
        load = 1'b0;

        // Load exactly in the boundary cycle that starts F3: F3 keeps 12AF, F4 shows BCDE.
        wait_frame();
        f.m = mk(G1, G2, GA, GF, 4'b0000, 4'b0000);
        f.z = mk(OFF, OFF, G3, G0, 4'b1100, 4'b0000);
        sb_q.push_back(f);
        f.m = mk(GB, GC, GD, GE, 4'b0000, 4'b0000);
        f.z = mk(OFF, OFF, OFF, G0, 4'b1110, 4'b0000);
        sb_q.push_back(f);
        repeat (15) @(negedge clk);
        value = 16'hBCDE; lz_value = 16'h0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;

        // Mid-F4: blank digit 2, decimal point on digit 0; LZ value 1000 keeps inner zeros.
        wait_frame();
        f.m = mk(G5, OFF, G7, G8, 4'b0100, 4'b0001);
        f.z = mk(G1, G0, G0, G0, 4'b0000, 4'b0000);
        sb_q.push_back(f);
        repeat (6) @(negedge clk);
        value = 16'h5678; blank_mask = 4'b0100; dp_mask = 4'b0001;
        lz_value = 16'h1000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;

        // During F5: pending load then reset before it commits; it must never appear.
        wait_frame();
        f.m = mk(G0, G0, G0, G0, 4'b0000, 4'b0000);
        f.z = mk(OFF, OFF, OFF, G0, 4'b1110, 4'b0000);
        sb_q.push_back(f);
        repeat (14) @(negedge clk);
        value = 16'h9999; blank_mask = 4'b0000; dp_mask = 4'b1111;
        lz_value = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_pins("midrst", 4'b1111, OFF, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk_pins("postrst", 4'b1110, G0, 1'b1);

        n = 0;
        while (frames_done < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", frames_done, 6);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
